// File: rtl/first_counter_mon_pkg.sv
// ---------------------------------------------------------------------------
// first_counter_mon_pkg : shared types and error codes for the counter monitor
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package first_counter_mon_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE           = 2'b00;
  localparam logic [1:0] ERR_COUNT_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_OVF_DROP       = 2'b10;
  localparam logic [1:0] ERR_OVF_EARLY      = 2'b11;

endpackage

`default_nettype wire

// File: rtl/first_counter_mon_check.sv
// ---------------------------------------------------------------------------
// first_counter_mon_check : expected-count, prioritised error code, wrap detect
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module first_counter_mon_check
  import first_counter_mon_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev_cnt,
  input  logic             prev_en,
  input  logic             ovf_exp,
  input  logic [WIDTH-1:0] counter_in,
  input  logic             overflow_in,
  output logic             err_hit,
  output logic [1:0]       err_code,
  output logic             wrap_hit
);

  localparam logic [WIDTH-1:0] C_CNT_MAX = '1;

  logic [WIDTH-1:0] w_expected;

  assign w_expected = prev_en ? prev_cnt + WIDTH'(1) : prev_cnt;

  // Count mismatch outranks either overflow disagreement.
  always_comb begin
    err_code = ERR_NONE;
    if (counter_in != w_expected)
      err_code = ERR_COUNT_MISMATCH;
    else if (ovf_exp && !overflow_in)
      err_code = ERR_OVF_DROP;
    else if (!ovf_exp && overflow_in)
      err_code = ERR_OVF_EARLY;
  end

  assign err_hit  = (err_code != ERR_NONE);
  assign wrap_hit = prev_en && (prev_cnt == C_CNT_MAX) &&
                    (counter_in == '0) && !err_hit;

endmodule

`default_nettype wire

// File: rtl/first_counter_monitor.sv
// ---------------------------------------------------------------------------
// first_counter_monitor : passive protocol checker for a 4-bit sticky-overflow up-counter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module first_counter_monitor
  import first_counter_mon_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [WIDTH-1:0]  counter_in,
  input  logic              overflow_in,
  input  logic              clear,
  output logic              locked,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              wrap_pulse,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              err_pulse
);

  localparam logic [WIDTH-1:0]  C_CNT_MAX  = '1;
  localparam logic [WRAP_W-1:0] C_WRAP_MAX = '1;

  state_e            r_state;
  logic [WIDTH-1:0]  r_prev_cnt;
  logic              r_prev_en;
  logic              r_ovf_exp;
  logic              r_locked;
  logic [WRAP_W-1:0] r_wrap_count;
  logic              r_wrap_pulse;
  logic              r_err;
  logic [1:0]        r_err_code;
  logic              r_err_pulse;

  logic              w_err_hit;
  logic [1:0]        w_err_code;
  logic              w_wrap_hit;
  logic              w_cnt_at_max;

  assign w_cnt_at_max = (counter_in == C_CNT_MAX);

  first_counter_mon_check #(
    .WIDTH (WIDTH)
  ) u_check (
    .prev_cnt    (r_prev_cnt),
    .prev_en     (r_prev_en),
    .ovf_exp     (r_ovf_exp),
    .counter_in  (counter_in),
    .overflow_in (overflow_in),
    .err_hit     (w_err_hit),
    .err_code    (w_err_code),
    .wrap_hit    (w_wrap_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= SYNC;
      r_prev_cnt   <= '0;
      r_prev_en    <= 1'b0;
      r_ovf_exp    <= 1'b0;
      r_locked     <= 1'b0;
      r_wrap_count <= '0;
      r_wrap_pulse <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_err_pulse  <= 1'b0;
    end else if (clear) begin
      // prev_cnt/prev_en are recaptured in SYNC, so they are left alone here.
      r_state      <= SYNC;
      r_ovf_exp    <= 1'b0;
      r_locked     <= 1'b0;
      r_wrap_count <= '0;
      r_wrap_pulse <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_err_pulse  <= 1'b0;
    end else begin
      r_wrap_pulse <= 1'b0;
      r_err_pulse  <= 1'b0;
      case (r_state)
        SYNC: begin
          r_prev_cnt <= counter_in;
          r_prev_en  <= enable;
          if (w_cnt_at_max)
            r_ovf_exp <= 1'b1;
          r_state  <= TRACK;
          r_locked <= 1'b1;
        end
        TRACK: begin
          if (w_err_hit) begin
            r_state     <= ERROR;
            r_locked    <= 1'b0;
            r_err       <= 1'b1;
            r_err_code  <= w_err_code;
            r_err_pulse <= 1'b1;
          end else begin
            r_prev_cnt <= counter_in;
            r_prev_en  <= enable;
            if (w_cnt_at_max)
              r_ovf_exp <= 1'b1;
            if (w_wrap_hit) begin
              r_wrap_pulse <= 1'b1;
              if (r_wrap_count != C_WRAP_MAX)
                r_wrap_count <= r_wrap_count + WRAP_W'(1);
            end
          end
        end
        ERROR: begin
          r_state <= ERROR;
        end
        default: begin
          r_state  <= SYNC;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign locked     = r_locked;
  assign wrap_count = r_wrap_count;
  assign wrap_pulse = r_wrap_pulse;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign err_pulse  = r_err_pulse;

endmodule

`default_nettype wire

// File: doc/first_counter_monitor.md
# first_counter_monitor

Passive checker at the receive end of the 4-bit up-counter interface (enable, count, sticky overflow). It samples the enable strobe, count value and overflow flag, predicts each cycle's expected count and overflow, counts wrap-arounds, and latches the first protocol violation. It sits beside the counter in simulation and on-chip debug builds and never drives the counter.

## Interface
- WIDTH, 4, width of monitored count
- WRAP_W, 8, width of wrap counter
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; shared with the monitored counter
- enable  in  1  increment strobe as presented to the counter
- counter_in  in  WIDTH  counter's registered count
- overflow_in  in  1  counter's sticky overflow flag
- clear  in  1  synchronous clear of statistics and error; re-enters SYNC
- locked  out  1  high while in TRACK
- wrap_count  out  WRAP_W  number of max→0 wraps, saturating
- wrap_pulse  out  1  one-cycle pulse per wrap
- err  out  1  sticky error flag
- err_code  out  2  code of first error: 00 none, 01 COUNT_MISMATCH, 10 OVF_DROP, 11 OVF_EARLY
- err_pulse  out  1  one-cycle pulse when err sets

## Operation
- Counter protocol: enable sampled high at edge t gives counter_in = prev+1 (mod 2^WIDTH) after edge t; enable low holds value. After any edge sampling counter_in = all-ones, overflow_in must be 1 and stays 1 until reset.
- Registers: prev_cnt, prev_en, ovf_exp (sticky: set when counter_in = all-ones is sampled).
- States: SYNC, TRACK, ERROR.
- SYNC: capture prev_cnt ← counter_in, prev_en ← enable, set ovf_exp if counter_in = all-ones; no checks; → TRACK next cycle.
- TRACK: expected = prev_en ? prev_cnt+1 : prev_cnt, modulo 2^WIDTH. Checks, priority order: counter_in ≠ expected → 01; ovf_exp=1 and overflow_in=0 → 10; ovf_exp=0 and overflow_in=1 → 11. Any error → ERROR, latch err=1 and err_code, pulse err_pulse. Otherwise update prev_cnt/prev_en/ovf_exp.
- Wrap: in TRACK, prev_en=1, prev_cnt = all-ones, counter_in = 0 and no error that cycle → wrap_pulse, wrap_count+1, holding at all-ones once saturated.
- ERROR: all checks and wrap counting frozen; err/err_code held; leaves only on clear or reset.
- clear (any state): → SYNC; wrap_count, err, err_code, ovf_exp ← 0. clear wins over a simultaneous error or wrap.
- reset: same as clear plus all registers and outputs zero.

## Timing
- Reset values: locked=0, wrap_count=0, wrap_pulse=0, err=0, err_code=00, err_pulse=0; state SYNC.
- First check is on the second sample after reset or clear deasserts (the SYNC cycle is a capture only).
- All outputs are registered. err, err_code and err_pulse update at the edge that samples the offending values and are visible for the cycle after it. wrap_pulse and wrap_count behave the same way.
- locked rises the cycle after SYNC and falls the cycle after entry to ERROR or clear.
- No combinational input-to-output path.

## Structure
- Package first_counter_mon_pkg: state enum {SYNC, TRACK, ERROR}; err_code constants ERR_NONE, ERR_COUNT_MISMATCH, ERR_OVF_DROP, ERR_OVF_EARLY.
- One sub-module, first_counter_mon_check: combinational expected-count computation, priority error encoding and wrap detect. The top holds the FSM, prev/ovf_exp registers and saturating wrap_count.

## Test plan
- Reset, enable=1 for 20 cycles with a correct counter model: counter_in 0..15,0..3 → wrap_pulse once, wrap_count=1, overflow_in high from the cycle after 15 with no error, err=0.
- Legal sequence but counter_in jumps 5→7 with enable=1 → err=1, err_code=01, err_pulse for one cycle, locked=0; further traffic leaves wrap_count unchanged.
- overflow_in forced 0 two cycles after 15 is sampled → err_code=10.
- overflow_in=1 while count=3, never having reached 15 → err_code=11. In the same scenario with counter_in also wrong, the code is 01 (priority).
- 300 wraps, WRAP_W=8 → wrap_count saturates at 255. clear asserted on the same cycle as a wrap → wrap_count=0, no wrap_pulse, state SYNC.
- reset mid-run while in ERROR → all outputs zero next cycle; re-locks and checks a fresh 0..15 run cleanly.
